// File: rtl/instr_decode_00_pkg.sv
// instr_decode_00_pkg: opcodes, FSM encoding, ISA field positions and decode record
package instr_decode_00_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int IMM_HI = 15;
    localparam int JA_HI  = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [31:0] imm_ext;
        logic [25:0] jaddr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec_t;
endpackage

// File: rtl/instr_decode_00_if.sv
// instr_decode_00_if: fetch-side and execute-side handshakes of the decode stage
interface instr_decode_00_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
    logic        id_valid;
    logic        id_ready;

    modport master (
        output if_valid, if_instr, id_ready,
        input  if_ready, rs, rt, rd, opcode, funct, shamt, imm_ext, jaddr,
               reg_write, mem_read, mem_write, is_branch, is_jump, illegal, id_valid
    );

    modport slave (
        input  if_valid, if_instr, id_ready,
        output if_ready, rs, rt, rd, opcode, funct, shamt, imm_ext, jaddr,
               reg_write, mem_read, mem_write, is_branch, is_jump, illegal, id_valid
    );
endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational IR to control bits, destination index and immediate
module instr_field_decode
    import instr_decode_00_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);
    logic [5:0] op;
    logic       r_type, addi, andi, ori, lw, sw, beq, jmp, i_wr;
    logic [4:0] rd_r;

    assign op     = ir[OP_HI:OP_LO];
    assign r_type = op == OP_RTYPE;
    assign addi   = op == OP_ADDI;
    assign andi   = op == OP_ANDI;
    assign ori    = op == OP_ORI;
    assign lw     = op == OP_LW;
    assign sw     = op == OP_SW;
    assign beq    = op == OP_BEQ;
    assign jmp    = op == OP_J;
    assign i_wr   = addi || andi || ori || lw;
    assign rd_r   = r_type ? ir[RD_HI:RD_LO] : i_wr ? ir[RT_HI:RT_LO] : 5'd0;

    assign dec.opcode    = op;
    assign dec.funct     = r_type ? ir[FN_HI:0] : 6'd0;
    assign dec.shamt     = r_type ? ir[SH_HI:SH_LO] : 5'd0;
    assign dec.rd        = rd_r;
    assign dec.imm_ext   = (andi || ori) ? {16'd0, ir[IMM_HI:0]} : {{16{ir[IMM_HI]}}, ir[IMM_HI:0]};
    assign dec.jaddr     = ir[JA_HI:0];
    assign dec.reg_write = (r_type || i_wr) && (rd_r != 5'd0);
    assign dec.mem_read  = lw;
    assign dec.mem_write = sw;
    assign dec.is_branch = beq;
    assign dec.is_jump   = jmp;
    assign dec.illegal   = !(r_type || i_wr || sw || beq || jmp);
endmodule

// File: rtl/instr_decode_00.sv
// instr_decode_00: instruction register, 3-state sequencing FSM and registered decode outputs
module instr_decode_00
    import instr_decode_00_pkg::*;
(
    input logic              clk,
    input logic              rst,
    instr_decode_00_if.slave bus
);
    state_t      state, state_nx;
    logic        run, take;
    logic [31:0] ir;
    dec_t        dec_c, dec_q;

    instr_field_decode u_field (.ir(ir), .dec(dec_c));

    assign bus.if_ready  = run && (state == IDLE || (state == OUT && bus.id_ready));
    assign bus.id_valid  = state == OUT;
    assign take          = bus.if_valid && bus.if_ready;
    assign bus.rs        = ir[RS_HI:RS_LO];
    assign bus.rt        = ir[RT_HI:RT_LO];
    assign bus.rd        = dec_q.rd;
    assign bus.opcode    = dec_q.opcode;
    assign bus.funct     = dec_q.funct;
    assign bus.shamt     = dec_q.shamt;
    assign bus.imm_ext   = dec_q.imm_ext;
    assign bus.jaddr     = dec_q.jaddr;
    assign bus.reg_write = dec_q.reg_write;
    assign bus.mem_read  = dec_q.mem_read;
    assign bus.mem_write = dec_q.mem_write;
    assign bus.is_branch = dec_q.is_branch;
    assign bus.is_jump   = dec_q.is_jump;
    assign bus.illegal   = dec_q.illegal;

    // Next state: DECODE lasts one cycle, OUT waits for execute, a fetch accept always enters DECODE
    always_comb begin
        state_nx = state;
        if (take) state_nx = DECODE;
        else if (state == DECODE) state_nx = OUT;
        else if (state == OUT && bus.id_ready) state_nx = IDLE;
        else if (state != OUT) state_nx = IDLE;
    end

    // State register; run keeps if_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    // IR loads on a fetch accept; decode results are captured at the end of DECODE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir    <= '0;
            dec_q <= '0;
        end else begin
            if (take) ir <= bus.if_instr;
            if (state == DECODE) dec_q <= dec_c;
        end
    end
endmodule

// File: tb/tb_instr_decode_00.sv
// tb_instr_decode_00: directed table, random model checks and handshake sequences for instr_decode_00
module tb_instr_decode_00;
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [5:0]  ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_decode_00_if bus ();
    instr_decode_00 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] act_ctl();
        return {bus.reg_write, bus.mem_read, bus.mem_write, bus.is_branch, bus.is_jump, bus.illegal};
    endfunction

    function automatic vec_t mk(input logic [31:0] w, input int s, input int t, input int d,
                                input int f, input int sh, input logic [31:0] im, input logic [5:0] c);
        vec_t v;
        v.instr = w; v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d);
        v.funct = 6'(f); v.shamt = 5'(sh); v.imm = im; v.ctl = c;
        return v;
    endfunction

    function automatic vec_t model(input logic [31:0] w);
        vec_t e;
        logic [15:0] lo;
        lo = w[15:0];
        e = '0;
        e.instr = w; e.rs = w[25:21]; e.rt = w[20:16];
        e.imm = {{16{lo[15]}}, lo};
        case (w[31:26])
            6'h00: begin e.rd = w[15:11]; e.funct = w[5:0]; e.shamt = w[10:6]; e.ctl = 6'b100000; end
            6'h08: begin e.rd = w[20:16]; e.ctl = 6'b100000; end
            6'h0C, 6'h0D: begin e.rd = w[20:16]; e.imm = {16'd0, lo}; e.ctl = 6'b100000; end
            6'h23: begin e.rd = w[20:16]; e.ctl = 6'b110000; end
            6'h2B: e.ctl = 6'b001000;
            6'h04: e.ctl = 6'b000100;
            6'h02: e.ctl = 6'b000010;
            default: e.ctl = 6'b000001;
        endcase
        if (e.rd == 5'd0) e.ctl[5] = 1'b0;
        return e;
    endfunction

    task automatic check_dec(input string tag, input vec_t e);
        chk({tag, ".rs"}, 32'(bus.rs), 32'(e.rs));
        chk({tag, ".rt"}, 32'(bus.rt), 32'(e.rt));
        chk({tag, ".rd"}, 32'(bus.rd), 32'(e.rd));
        chk({tag, ".opcode"}, 32'(bus.opcode), 32'(e.instr[31:26]));
        chk({tag, ".funct"}, 32'(bus.funct), 32'(e.funct));
        chk({tag, ".shamt"}, 32'(bus.shamt), 32'(e.shamt));
        chk({tag, ".imm_ext"}, bus.imm_ext, e.imm);
        chk({tag, ".jaddr"}, 32'(bus.jaddr), 32'(e.instr[25:0]));
        chk({tag, ".ctl"}, 32'(act_ctl()), 32'(e.ctl));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        #1;
        while (!bus.if_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".if_ready_timeout"}, 32'(bus.if_ready), 32'd1);
    endtask

    task automatic run_one(input string tag, input vec_t e);
        bus.if_valid = 1'b1;
        bus.if_instr = e.instr;
        bus.id_ready = 1'b0;
        wait_ready(tag);
        tick();
        bus.if_valid = 1'b0;
        chk({tag, ".decode_id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, ".decode_rs"}, 32'(bus.rs), 32'(e.rs));
        tick();
        chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'd1);
        check_dec(tag, e);
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
    endtask

    vec_t tbl[12];
    logic [5:0] ops[8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};

    initial begin
        vec_t a, b, q[$], got;
        logic [31:0] words[8];
        int idx, pulses, last, take_now;

        tbl[0]  = mk(32'h2065FFFC, 3, 5, 5, 0,    0, 32'hFFFFFFFC, 6'b100000);
        tbl[1]  = mk(32'h34078001, 0, 7, 7, 0,    0, 32'h00008001, 6'b100000);
        tbl[2]  = mk(32'h00220020, 1, 2, 0, 'h20, 0, 32'h00000020, 6'b000000);
        tbl[3]  = mk(32'hAC650008, 3, 5, 0, 0,    0, 32'h00000008, 6'b001000);
        tbl[4]  = mk(32'h1022FFFF, 1, 2, 0, 0,    0, 32'hFFFFFFFF, 6'b000100);
        tbl[5]  = mk(32'h08000100, 0, 0, 0, 0,    0, 32'h00000100, 6'b000010);
        tbl[6]  = mk(32'hFC000000, 0, 0, 0, 0,    0, 32'h00000000, 6'b000001);
        tbl[7]  = mk(32'h8C89FFF8, 4, 9, 9, 0,    0, 32'hFFFFFFF8, 6'b110000);
        tbl[8]  = mk(32'h3022F0F0, 1, 2, 2, 0,    0, 32'h0000F0F0, 6'b100000);
        tbl[9]  = mk(32'h00032140, 0, 3, 4, 0,    5, 32'h00002140, 6'b100000);
        tbl[10] = mk(32'h20200001, 1, 0, 0, 0,    0, 32'h00000001, 6'b000000);
        tbl[11] = mk(32'h3C01FFFF, 0, 1, 0, 0,    0, 32'hFFFFFFFF, 6'b000001);

        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.id_ready = 1'b0;

        #12;
        chk("reset.if_ready", 32'(bus.if_ready), 32'd0);
        chk("reset.id_valid", 32'(bus.id_valid), 32'd0);
        chk("reset.rs", 32'(bus.rs), 32'd0);
        chk("reset.ctl", 32'(act_ctl()), 32'd0);
        rst = 1'b1;
        tick();
        chk("release.if_ready", 32'(bus.if_ready), 32'd1);

        foreach (tbl[i]) run_one($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 30; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 8) == 8) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            run_one($sformatf("rnd%0d", i), model({op, 26'($urandom)}));
        end

        a = model(32'h2065FFFC);
        b = model(32'h8C89FFF8);
        bus.if_valid = 1'b1; bus.if_instr = a.instr; bus.id_ready = 1'b0;
        wait_ready("bp");
        tick();
        bus.if_instr = b.instr;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp.if_ready", 32'(bus.if_ready), 32'd0);
            chk("bp.id_valid", 32'(bus.id_valid), 32'd1);
            check_dec("bp.hold", a);
            tick();
        end
        bus.id_ready = 1'b1;
        #1;
        chk("bp.release_if_ready", 32'(bus.if_ready), 32'd1);
        tick();
        bus.if_valid = 1'b0; bus.id_ready = 1'b0;
        chk("bp.after_id_valid", 32'(bus.id_valid), 32'd0);
        chk("bp.new_rs", 32'(bus.rs), 32'(b.rs));
        tick();
        chk("bp.next_id_valid", 32'(bus.id_valid), 32'd1);
        check_dec("bp.second", b);
        bus.id_ready = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) words[i] = {ops[$urandom_range(0, 7)], 26'($urandom)};
        idx = 0; pulses = 0; last = -1;
        for (int c = 0; c < 40; c++) begin
            bus.if_valid = idx < 8;
            bus.if_instr = words[idx < 8 ? idx : 7];
            #1;
            if (bus.id_valid) begin
                if (q.size() == 0) chk("b2b.unexpected_pulse", 32'd1, 32'd0);
                else begin
                    got = q.pop_front();
                    check_dec($sformatf("b2b%0d", pulses), got);
                end
                if (last >= 0) chk("b2b.gap", 32'(c - last), 32'd2);
                last = c;
                pulses++;
            end
            take_now = int'(bus.if_valid && bus.if_ready);
            tick();
            if (take_now != 0) begin
                q.push_back(model(words[idx]));
                idx++;
            end
        end
        chk("b2b.pulses", 32'(pulses), 32'd8);
        chk("b2b.leftover", 32'(q.size()), 32'd0);
        bus.if_valid = 1'b0; bus.id_ready = 1'b0;
        tick();

        bus.if_valid = 1'b1; bus.if_instr = 32'h34078001;
        wait_ready("rst");
        tick();
        bus.if_valid = 1'b0;
        tick();
        chk("rst.pre_id_valid", 32'(bus.id_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst.id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst.if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst.rs_rt", 32'({bus.rs, bus.rt}), 32'd0);
        chk("rst.rd", 32'(bus.rd), 32'd0);
        chk("rst.imm_ext", bus.imm_ext, 32'd0);
        chk("rst.ctl", 32'(act_ctl()), 32'd0);
        tick();
        chk("rst.held_if_ready", 32'(bus.if_ready), 32'd0);
        #2 rst = 1'b1;
        tick();
        chk("rst.release_if_ready", 32'(bus.if_ready), 32'd1);
        chk("rst.release_id_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("rst.idle_id_valid", 32'(bus.id_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
